// File: rtl/fir_pair_serializer_if.sv
// Handshake bundle for fir_pair_serializer: pair input stream, serial sample output stream, FIFO level.
// The sat_count signal exists only when SAT_COUNT_EN is defined.
interface fir_pair_serializer_if #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data1;
  logic [IN_W-1:0]  in_data2;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [LW-1:0]    fifo_level;

`ifdef SAT_COUNT_EN
  logic [15:0]      sat_count;

  modport slave (
    input  in_valid, in_data1, in_data2, out_ready,
    output in_ready, out_valid, out_data, fifo_level, sat_count
  );
  modport master (
    output in_valid, in_data1, in_data2, out_ready,
    input  in_ready, out_valid, out_data, fifo_level, sat_count
  );
`else
  modport slave (
    input  in_valid, in_data1, in_data2, out_ready,
    output in_ready, out_valid, out_data, fifo_level
  );
  modport master (
    output in_valid, in_data1, in_data2, out_ready,
    input  in_ready, out_valid, out_data, fifo_level
  );
`endif
endinterface

// File: rtl/fir_pair_serializer.sv
// Buffers FIR result pairs in a FIFO, rounds/saturates each sample and streams them out in time order.
// Optional SAT_COUNT_EN adds a saturating 16-bit count of clipped samples.
module fir_pair_serializer #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 8,
  parameter int SHIFT = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  fir_pair_serializer_if.slave io
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT-1);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_e;

  // One extra bit of headroom keeps the rounding add from wrapping.
  function automatic logic [IN_W:0] rnd_shift(input logic [IN_W-1:0] x);
    return ({1'b0, x} + RND) >> SHIFT;
  endfunction

  function automatic logic is_sat(input logic [IN_W-1:0] x);
    return (rnd_shift(x) >> OUT_W) != '0;
  endfunction

  function automatic logic [OUT_W-1:0] conv(input logic [IN_W-1:0] x);
    logic [IN_W:0] r;
    r = rnd_shift(x);
    return is_sat(x) ? {OUT_W{1'b1}} : r[OUT_W-1:0];
  endfunction

  state_e              state_q, state_d;
  logic [2*IN_W-1:0]   mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q, level_d;
  logic [OUT_W-1:0]    out_q, out_d, hold_q, hold_d;
  logic [IN_W-1:0]     head1, head2;
  logic                push, pop, fifo_empty;

  assign io.in_ready   = !rst && (level_q != LW'(DEPTH));
  assign push          = io.in_valid && io.in_ready;
  assign fifo_empty    = (level_q == '0);
  assign head1         = mem_q[rd_ptr_q][2*IN_W-1:IN_W];
  assign head2         = mem_q[rd_ptr_q][IN_W-1:0];
  assign io.out_valid  = (state_q != IDLE);
  assign io.out_data   = out_q;
  assign io.fifo_level = level_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = FIRST;
        end
      end
      FIRST: begin
        if (io.out_ready) begin
          out_d   = hold_q;
          state_d = SECOND;
        end
      end
      SECOND: begin
        // Reload straight from the FIFO so a back-to-back pair has no bubble.
        if (io.out_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = FIRST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      out_d  = conv(head1);
      hold_d = conv(head2);
    end
    level_d = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      out_q    <= '0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      hold_q   <= hold_d;
      level_q  <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset: the level/pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {io.in_data1, io.in_data2};
  end

`ifdef SAT_COUNT_EN
  logic [15:0] sat_count_q, sat_count_d;
  logic [16:0] sat_sum;

  assign sat_sum     = {1'b0, sat_count_q} + 17'(is_sat(head1)) + 17'(is_sat(head2));
  assign sat_count_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  assign io.sat_count = sat_count_q;

  always_ff @(posedge clk) begin
    if (rst)      sat_count_q <= '0;
    else if (pop) sat_count_q <= sat_count_d;
  end
`endif
endmodule

// File: tb/tb_fir_pair_serializer.sv
// Directed + randomized bench for fir_pair_serializer with a queue-based sample scoreboard.
module tb_fir_pair_serializer;
  localparam int IN_W  = 20;
  localparam int OUT_W = 8;
  localparam int SHIFT = 12;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   exp_q[$];
  int   got_q[$];

  fir_pair_serializer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

  fir_pair_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_conv(int x);
    int r = (x + (1 << (SHIFT-1))) / (1 << SHIFT);
    return (r > (1 << OUT_W) - 1) ? (1 << OUT_W) - 1 : r;
  endfunction

  function automatic logic [IN_W-1:0] rnd_sample();
    if ($urandom_range(0, 3) == 0) return IN_W'($urandom_range(1040000, (1 << IN_W) - 1));
    return IN_W'($urandom_range(0, (1 << IN_W) - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: record handshakes before the edge, update the model, check stall stability after.
  task automatic tick(output bit psh);
    bit pp, stall, in_rst;
    logic [OUT_W-1:0] od;
    int e;
    #1;
    in_rst = rst;
    psh    = !in_rst && bus.in_valid && bus.in_ready;
    pp     = !in_rst && bus.out_valid && bus.out_ready;
    stall  = !in_rst && bus.out_valid && !bus.out_ready;
    od     = bus.out_data;
    if (pp) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      chk("out_sample", 32'(od), e);
      got_q.push_back(int'(od));
    end
    if (psh) begin
      exp_q.push_back(ref_conv(int'(bus.in_data1)));
      exp_q.push_back(ref_conv(int'(bus.in_data2)));
    end
    @(posedge clk);
    #1;
    if (in_rst) exp_q.delete();
    if (stall) begin
      chk("stall_valid", 32'(bus.out_valid), 1);
      chk("stall_data", 32'(bus.out_data), 32'(od));
    end
  endtask

  task automatic step();
    bit d;
    tick(d);
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < max) begin
      step();
      n++;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_idle"}, 32'(bus.out_valid), 0);
  endtask

  task automatic chk_got(input string tag, input int exp_list[$]);
    chk({tag, "_count"}, got_q.size(), exp_list.size());
    for (int i = 0; i < exp_list.size(); i++)
      chk({tag, "_val"}, (i < got_q.size()) ? got_q[i] : -1, exp_list[i]);
  endtask

  initial begin
    bit p;
    int exp_list[$];
    int seen, bubbles, acc_late, pushed;
    logic [IN_W-1:0] pa, pb, qa, qb;

    // Reset
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_data1 = '0; bus.in_data2 = '0;
    step(); step();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_level", 32'(bus.fifo_level), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    // Basic conversion and latency
    got_q.delete();
    bus.in_data1 = 20'd4096; bus.in_data2 = 20'd8192; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick(p);
    chk("t1_accept", 32'(p), 1);
    bus.in_valid = 1'b0;
    chk("t1_lat_valid", 32'(bus.out_valid), 0);
    chk("t1_level", 32'(bus.fifo_level), 1);
    step();
    chk("t1_d1_valid", 32'(bus.out_valid), 1);
    chk("t1_d1", 32'(bus.out_data), 1);
    step();
    chk("t1_d2_valid", 32'(bus.out_valid), 1);
    chk("t1_d2", 32'(bus.out_data), 2);
    step();
    chk("t1_fall", 32'(bus.out_valid), 0);
    chk("t1_left", exp_q.size(), 0);

    // Rounding and saturation boundaries
    got_q.delete();
    bus.in_data1 = 20'd2047; bus.in_data2 = 20'd2048; bus.in_valid = 1'b1;
    step();
    bus.in_data1 = 20'd1046527; bus.in_data2 = 20'd1048575;
    step();
    bus.in_valid = 1'b0;
    drain("t2", 20);
    exp_list = '{0, 1, 255, 255};
    chk_got("t2", exp_list);
`ifdef SAT_COUNT_EN
    chk("t2_sat_count", 32'(bus.sat_count), 1);
`endif

    // Backpressure until full
    got_q.delete();
    bus.out_ready = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      bus.in_data1 = IN_W'(4096 * n); bus.in_data2 = IN_W'(4096 * n + 4096); bus.in_valid = 1'b1;
      if (n == 6) chk("t3_full_ready", 32'(bus.in_ready), 0);
      tick(p);
      chk("t3_accept", 32'(p), (n < 6) ? 1 : 0);
    end
    bus.in_valid = 1'b0;
    chk("t3_level", 32'(bus.fifo_level), 4);
    chk("t3_in_ready", 32'(bus.in_ready), 0);
    chk("t3_head", 32'(bus.out_data), 1);
    step(); step();
    bus.out_ready = 1'b1;
    drain("t3", 30);
    exp_list.delete();
    for (int n = 1; n <= 5; n++) begin
      exp_list.push_back(n);
      exp_list.push_back(n + 1);
    end
    chk_got("t3", exp_list);

    // Streaming with random data, out_ready held high
    got_q.delete();
    seen = 0; bubbles = 0; acc_late = 0; pushed = 0;
    bus.in_data1 = rnd_sample(); bus.in_data2 = rnd_sample(); bus.in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick(p);
      if (p) begin
        pushed++;
        if (c >= 20) acc_late++;
        bus.in_data1 = rnd_sample(); bus.in_data2 = rnd_sample();
      end
      if (seen != 0 && !bus.out_valid) bubbles++;
      if (bus.out_valid) seen = 1;
    end
    bus.in_valid = 1'b0;
    chk("t4_bubbles", bubbles, 0);
    chk("t4_ready_alt", acc_late, 10);
    drain("t4", 40);
    chk("t4_count", got_q.size(), 2 * pushed);

    // Stall in SECOND, then next pair follows without an idle cycle
    got_q.delete();
    pa = rnd_sample(); pb = rnd_sample(); qa = rnd_sample(); qb = rnd_sample();
    bus.out_ready = 1'b0;
    bus.in_data1 = pa; bus.in_data2 = pb; bus.in_valid = 1'b1;
    step();
    bus.in_data1 = qa; bus.in_data2 = qb;
    step();
    bus.in_valid = 1'b0;
    chk("t5_first", 32'(bus.out_data), ref_conv(int'(pa)));
    bus.out_ready = 1'b1;
    step();
    chk("t5_second", 32'(bus.out_data), ref_conv(int'(pb)));
    bus.out_ready = 1'b0;
    step(); step();
    chk("t5_held", 32'(bus.out_data), ref_conv(int'(pb)));
    bus.out_ready = 1'b1;
    step();
    chk("t5_no_gap", 32'(bus.out_valid), 1);
    chk("t5_next", 32'(bus.out_data), ref_conv(int'(qa)));
    drain("t5", 10);
    chk("t5_count", got_q.size(), 4);

    // Reset mid-operation with three pairs queued and the FSM in SECOND
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      bus.in_data1 = rnd_sample(); bus.in_data2 = rnd_sample();
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t6_level", 32'(bus.fifo_level), 3);
    chk("t6_valid", 32'(bus.out_valid), 1);
    rst = 1'b1;
    step();
    chk("t6_rst_valid", 32'(bus.out_valid), 0);
    chk("t6_rst_data", 32'(bus.out_data), 0);
    chk("t6_rst_level", 32'(bus.fifo_level), 0);
    rst = 1'b0;
    #1;
    chk("t6_in_ready", 32'(bus.in_ready), 1);
    got_q.delete();
    bus.in_data1 = 20'd4096; bus.in_data2 = 20'd4096; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    drain("t6", 10);
    exp_list = '{1, 1};
    chk_got("t6", exp_list);

    // Random valid/ready traffic against the scoreboard
    bus.in_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!bus.in_valid) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data1 = rnd_sample(); bus.in_data2 = rnd_sample();
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("t7_in_ready", 32'(bus.in_ready), (bus.fifo_level != DEPTH) ? 1 : 0);
      tick(p);
      if (p) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("t7", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
